mem_access_unit: RTL and testbench

- MEM-stage load/store engine of the 5-stage RV32 pipeline.
- Takes the EX/MEM control and address/data, runs one transaction per memory instruction on a valid/ready data-memory bus, and formats load data into the value latched by the MEM/WB register.
- Drives the stall that holds the pipeline-register enables low until the access completes.

---
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one valid/ready data-memory transaction
// per load/store, formats load data for MEM/WB and stalls the pipeline meanwhile.
module mem_access_unit #(
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_ctrl_mem,
  input  logic        mem_write_ctrl_mem,
  input  logic [1:0]  mem_size_mem,
  input  logic        mem_unsigned_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] rs2_data_mem,
  input  logic        hold_mem,
  output logic [31:0] mem_data_out_mem,
  output logic        stall_mem,
  output logic        misaligned_mem,
  output logic        timeout_err,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_be,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_rdata
);

  localparam int unsigned CW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          access, illegal, legal;
  logic [31:0]   store_wdata;
  logic [3:0]    store_be;
  logic [1:0]    lane_q, size_q;
  logic          unsigned_q, load_q;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_fmt;
  logic          resp_hit, timeout_hit;

  always_comb begin
    access  = mem_read_ctrl_mem | mem_write_ctrl_mem;
    illegal = (mem_size_mem == 2'b11)
            | ((mem_size_mem == 2'b01) & alu_result_mem[0])
            | ((mem_size_mem == 2'b10) & (|alu_result_mem[1:0]));
    legal          = access & ~illegal;
    misaligned_mem = access & illegal;
  end

  always_comb begin
    store_wdata = rs2_data_mem;
    store_be    = 4'b1111;
    case (mem_size_mem)
      2'b00: begin
        store_wdata = {4{rs2_data_mem[7:0]}};
        store_be    = 4'b0001 << alu_result_mem[1:0];
      end
      2'b01: begin
        store_wdata = {2{rs2_data_mem[15:0]}};
        store_be    = 4'b0011 << {alu_result_mem[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Lane and size were captured at issue, so formatting is independent of
  // whatever the EX/MEM inputs show while the response arrives.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = dmem_resp_rdata[7:0];
      2'd1:    byte_sel = dmem_resp_rdata[15:8];
      2'd2:    byte_sel = dmem_resp_rdata[23:16];
      default: byte_sel = dmem_resp_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? dmem_resp_rdata[31:16] : dmem_resp_rdata[15:0];
    case (size_q)
      2'b00:   load_fmt = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = {{16{~unsigned_q & half_sel[15]}}, half_sel};
      default: load_fmt = dmem_resp_rdata;
    endcase
  end

  always_comb begin
    resp_hit    = (state == WAIT_RESP) & dmem_resp_valid;
    timeout_hit = (state == WAIT_RESP) & ~dmem_resp_valid & (wait_cnt == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (legal && !hold_mem)        state_next = REQ;
      REQ:       if (dmem_req_ready)            state_next = WAIT_RESP;
      WAIT_RESP: if (resp_hit || timeout_hit)   state_next = DONE;
      DONE:      if (!hold_mem)                 state_next = IDLE;
      default:                                  state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_mem = 1'b0;
    case (state)
      IDLE:             stall_mem = legal;
      REQ, WAIT_RESP:   stall_mem = 1'b1;
      default:          stall_mem = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req_valid   <= 1'b0;
      dmem_req_we      <= 1'b0;
      dmem_req_addr    <= '0;
      dmem_req_wdata   <= '0;
      dmem_req_be      <= '0;
      mem_data_out_mem <= '0;
      timeout_err      <= 1'b0;
      wait_cnt         <= '0;
      lane_q           <= '0;
      size_q           <= '0;
      unsigned_q       <= 1'b0;
      load_q           <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      case (state)
        IDLE: begin
          if (legal && !hold_mem) begin
            dmem_req_valid <= 1'b1;
            dmem_req_we    <= ~mem_read_ctrl_mem;
            dmem_req_addr  <= {alu_result_mem[31:2], 2'b00};
            dmem_req_wdata <= store_wdata;
            dmem_req_be    <= store_be;
            lane_q         <= alu_result_mem[1:0];
            size_q         <= mem_size_mem;
            unsigned_q     <= mem_unsigned_mem;
            load_q         <= mem_read_ctrl_mem;
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            wait_cnt       <= '0;
          end
        end
        WAIT_RESP: begin
          if (dmem_resp_valid) begin
            if (load_q) mem_data_out_mem <= load_fmt;
          end else if (wait_cnt == CNT_LAST) begin
            mem_data_out_mem <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed and random loads/stores
// checked against an arithmetic model of the memory-access rules.
module tb_mem_access_unit;

  localparam int unsigned RESP_TIMEOUT = 64;

  logic        clk;
  logic        reset;
  logic        mem_read_ctrl_mem;
  logic        mem_write_ctrl_mem;
  logic [1:0]  mem_size_mem;
  logic        mem_unsigned_mem;
  logic [31:0] alu_result_mem;
  logic [31:0] rs2_data_mem;
  logic        hold_mem;
  logic [31:0] mem_data_out_mem;
  logic        stall_mem;
  logic        misaligned_mem;
  logic        timeout_err;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_data;

  mem_access_unit #(.RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_read_ctrl_mem  (mem_read_ctrl_mem),
    .mem_write_ctrl_mem (mem_write_ctrl_mem),
    .mem_size_mem       (mem_size_mem),
    .mem_unsigned_mem   (mem_unsigned_mem),
    .alu_result_mem     (alu_result_mem),
    .rs2_data_mem       (rs2_data_mem),
    .hold_mem           (hold_mem),
    .mem_data_out_mem   (mem_data_out_mem),
    .stall_mem          (stall_mem),
    .misaligned_mem     (misaligned_mem),
    .timeout_err        (timeout_err),
    .dmem_req_valid     (dmem_req_valid),
    .dmem_req_ready     (dmem_req_ready),
    .dmem_req_we        (dmem_req_we),
    .dmem_req_addr      (dmem_req_addr),
    .dmem_req_wdata     (dmem_req_wdata),
    .dmem_req_be        (dmem_req_be),
    .dmem_resp_valid    (dmem_resp_valid),
    .dmem_resp_rdata    (dmem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_legal(logic rd, logic wr, logic [1:0] sz, logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return (a % 2) == 0;
      2'd2:    return (a % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(logic [1:0] sz, logic uns, logic [31:0] a, logic [31:0] word);
    int unsigned v;
    case (sz)
      2'd0: begin
        v = (word >> (8 * (a % 4))) % 256;
        if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (word >> (16 * ((a / 2) % 2))) % 65536;
        if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(logic [1:0] sz, logic [31:0] d);
    case (sz)
      2'd0:    return (d % 256) * 32'h0101_0101;
      2'd1:    return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] model_be(logic [1:0] sz, logic [31:0] a);
    case (sz)
      2'd0:    return 4'(1 << (a % 4));
      2'd1:    return 4'(3 << (2 * ((a / 2) % 2)));
      default: return 4'hF;
    endcase
  endfunction

  task automatic clear_inputs();
    mem_read_ctrl_mem  = 1'b0;
    mem_write_ctrl_mem = 1'b0;
    mem_size_mem       = 2'b00;
    mem_unsigned_mem   = 1'b0;
    alu_result_mem     = '0;
    rs2_data_mem       = '0;
    hold_mem           = 1'b0;
    dmem_req_ready     = 1'b0;
    dmem_resp_valid    = 1'b0;
    dmem_resp_rdata    = '0;
  endtask

  // Entered at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
  // resp_dly = 0 means the memory never answers.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input int ready_dly, input int resp_dly, input int hold_cyc,
                            input logic [31:0] rdata);
    logic legal;
    logic exp_mis;
    int   stalls;
    int   wait_cyc;
    legal   = is_legal(rd, wr, sz, addr);
    exp_mis = (rd || wr) && !legal;
    mem_read_ctrl_mem  = rd;
    mem_write_ctrl_mem = wr;
    mem_size_mem       = sz;
    mem_unsigned_mem   = uns;
    alu_result_mem     = addr;
    rs2_data_mem       = rs2;
    #1;
    total++;
    if (misaligned_mem !== exp_mis) begin
      bad++; $display("FAIL %s misaligned: got %b want %b", tag, misaligned_mem, exp_mis);
    end
    total++;
    if (stall_mem !== legal) begin
      bad++; $display("FAIL %s idle_stall: got %b want %b", tag, stall_mem, legal);
    end
    if (!legal) begin
      @(posedge clk); #1;
      total++;
      if (dmem_req_valid !== 1'b0 || stall_mem !== legal) begin
        bad++; $display("FAIL %s no_req: got valid=%b stall=%b want 0", tag, dmem_req_valid, stall_mem);
      end
      total++;
      if (mem_data_out_mem !== exp_data) begin
        bad++; $display("FAIL %s data_kept: got %h want %h", tag, mem_data_out_mem, exp_data);
      end
      clear_inputs();
      return;
    end
    stalls = 1;
    @(posedge clk); #1;
    for (int i = 0; i <= ready_dly; i++) begin
      total++;
      if ({dmem_req_valid, dmem_req_we, dmem_req_addr} !== {1'b1, !rd, addr & 32'hFFFF_FFFC}) begin
        bad++; $display("FAIL %s req: got v=%b we=%b a=%h want v=1 we=%b a=%h",
                        tag, dmem_req_valid, dmem_req_we, dmem_req_addr, !rd, addr & 32'hFFFF_FFFC);
      end
      if (!rd || sz == 2'd2) begin
        total++;
        if (dmem_req_be !== model_be(sz, addr)) begin
          bad++; $display("FAIL %s be: got %b want %b", tag, dmem_req_be, model_be(sz, addr));
        end
      end
      if (!rd) begin
        total++;
        if (dmem_req_wdata !== model_wdata(sz, rs2)) begin
          bad++; $display("FAIL %s wdata: got %h want %h", tag, dmem_req_wdata, model_wdata(sz, rs2));
        end
      end
      if (stall_mem) stalls++;
      dmem_req_ready  = (i == ready_dly);
      dmem_resp_valid = 1'($urandom % 2);
      dmem_resp_rdata = $urandom;
      @(posedge clk); #1;
    end
    dmem_req_ready = 1'b0;
    wait_cyc = (resp_dly > 0) ? resp_dly : RESP_TIMEOUT;
    for (int j = 1; j <= wait_cyc; j++) begin
      total++;
      if (dmem_req_valid !== 1'b0 || timeout_err !== 1'b0) begin
        bad++; $display("FAIL %s wait: got valid=%b tmo=%b want 0 0", tag, dmem_req_valid, timeout_err);
      end
      if (stall_mem) stalls++;
      dmem_resp_valid = (j == resp_dly);
      dmem_resp_rdata = (j == resp_dly) ? rdata : $urandom;
      @(posedge clk); #1;
    end
    if (resp_dly == 0)  exp_data = '0;
    else if (rd)        exp_data = model_load(sz, uns, addr, rdata);
    total++;
    if (stall_mem !== 1'b0 || dmem_req_valid !== 1'b0) begin
      bad++; $display("FAIL %s done: got stall=%b valid=%b want 0 0", tag, stall_mem, dmem_req_valid);
    end
    total++;
    if (mem_data_out_mem !== exp_data) begin
      bad++; $display("FAIL %s data: got %h want %h", tag, mem_data_out_mem, exp_data);
    end
    total++;
    if (timeout_err !== (resp_dly == 0)) begin
      bad++; $display("FAIL %s timeout_err: got %b want %b", tag, timeout_err, resp_dly == 0);
    end
    total++;
    if (stalls !== 2 + ready_dly + wait_cyc) begin
      bad++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, 2 + ready_dly + wait_cyc);
    end
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = $urandom;
    hold_mem        = (hold_cyc > 0);
    for (int k = 1; k <= hold_cyc; k++) begin
      @(posedge clk); #1;
      total++;
      if ({stall_mem, dmem_req_valid, timeout_err} !== 3'b000 || mem_data_out_mem !== exp_data) begin
        bad++; $display("FAIL %s hold_done: got stall=%b valid=%b tmo=%b data=%h want 0 0 0 %h",
                        tag, stall_mem, dmem_req_valid, timeout_err, mem_data_out_mem, exp_data);
      end
      if (k == hold_cyc) hold_mem = 1'b0;
    end
    clear_inputs();
    @(posedge clk); #1;
    total++;
    if ({stall_mem, dmem_req_valid, timeout_err} !== 3'b000 || mem_data_out_mem !== exp_data) begin
      bad++; $display("FAIL %s back_idle: got stall=%b valid=%b tmo=%b data=%h want 0 0 0 %h",
                      tag, stall_mem, dmem_req_valid, timeout_err, mem_data_out_mem, exp_data);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_data = '0;
    total++;
    if ({dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be} !== 70'd0) begin
      bad++; $display("FAIL reset_req: got v=%b we=%b a=%h d=%h be=%b want all 0",
                      dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be);
    end
    total++;
    if ({mem_data_out_mem, timeout_err, stall_mem, misaligned_mem} !== 35'd0) begin
      bad++; $display("FAIL reset_out: got data=%h tmo=%b stall=%b mis=%b want 0",
                      mem_data_out_mem, timeout_err, stall_mem, misaligned_mem);
    end
    reset = 1'b0;
  endtask

  task automatic test_load_word();
    run_access("lw_0x100", 1, 0, 2'd2, 0, 32'h100, 32'h0, 0, 2, 0, 32'hDEAD_BEEF);
  endtask

  task automatic test_load_formats();
    run_access("lb_0x103",  1, 0, 2'd0, 0, 32'h103, 32'h0, 0, 1, 0, 32'h80FF_0000);
    run_access("lbu_0x103", 1, 0, 2'd0, 1, 32'h103, 32'h0, 1, 2, 0, 32'h80FF_0000);
    run_access("lh_0x102",  1, 0, 2'd1, 0, 32'h102, 32'h0, 0, 1, 0, 32'h80FF_0000);
    run_access("lhu_0x102", 1, 0, 2'd1, 1, 32'h102, 32'h0, 0, 3, 0, 32'h80FF_0000);
    run_access("lb_0x000",  1, 0, 2'd0, 0, 32'h000, 32'h0, 0, 1, 0, 32'h1234_567F);
  endtask

  task automatic test_store();
    run_access("sb_0x201", 0, 1, 2'd0, 0, 32'h201, 32'h1234_5678, 0, 1, 0, 32'hAAAA_5555);
    run_access("sh_0x202", 0, 1, 2'd1, 0, 32'h202, 32'hCAFE_BABE, 2, 1, 0, 32'h0);
    run_access("sw_0x204", 0, 1, 2'd2, 0, 32'h204, 32'h0BAD_F00D, 1, 2, 0, 32'h0);
    run_access("rd_wr_lw", 1, 1, 2'd2, 0, 32'h208, 32'h0BAD_F00D, 0, 1, 0, 32'h7654_3210);
  endtask

  task automatic test_misaligned();
    run_access("lw_0x102",  1, 0, 2'd2, 0, 32'h102, 32'h0, 0, 1, 0, 32'h0);
    run_access("sz11_0x100", 1, 0, 2'd3, 0, 32'h100, 32'h0, 0, 1, 0, 32'h0);
    run_access("sh_0x101",  0, 1, 2'd1, 0, 32'h101, 32'h0, 0, 1, 0, 32'h0);
    run_access("no_access", 0, 0, 2'd2, 0, 32'h100, 32'h0, 0, 1, 0, 32'h0);
  endtask

  task automatic test_timeout();
    run_access("lw_timeout", 1, 0, 2'd2, 0, 32'h300, 32'h0, 5, 0, 0, 32'h0);
    run_access("lw_last_cycle_resp", 1, 0, 2'd2, 0, 32'h304, 32'h0, 0, RESP_TIMEOUT, 0, 32'h5A5A_A5A5);
  endtask

  task automatic test_hold_done();
    run_access("lh_hold_done", 1, 0, 2'd1, 1, 32'h400, 32'h0, 0, 1, 3, 32'h1111_F00F);
  endtask

  task automatic test_reset_midflight();
    mem_read_ctrl_mem = 1'b1;
    mem_size_mem      = 2'd2;
    alu_result_mem    = 32'h140;
    @(posedge clk); #1;
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    @(posedge clk); #1;
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset           = 1'b0;
    exp_data        = '0;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'h1122_3344;
    #1;
    total++;
    if ({dmem_req_valid, stall_mem, timeout_err} !== 3'b000 || mem_data_out_mem !== exp_data) begin
      bad++; $display("FAIL rst_mid_state: got valid=%b stall=%b tmo=%b data=%h want 0 0 0 %h",
                      dmem_req_valid, stall_mem, timeout_err, mem_data_out_mem, exp_data);
    end
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      dmem_resp_valid = 1'b0;
      total++;
      if ({dmem_req_valid, stall_mem, timeout_err} !== 3'b000 || mem_data_out_mem !== exp_data) begin
        bad++; $display("FAIL rst_mid_late_resp: got valid=%b stall=%b tmo=%b data=%h want 0 0 0 %h",
                        dmem_req_valid, stall_mem, timeout_err, mem_data_out_mem, exp_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        rd, wr, uns;
    logic [1:0]  sz;
    logic [31:0] addr;
    for (int t = 0; t < 40; t++) begin
      rd   = 1'($urandom % 2);
      wr   = 1'($urandom % 2);
      if (!rd && !wr && ($urandom % 4 != 0)) rd = 1'b1;
      sz   = 2'($urandom % 4);
      uns  = 1'($urandom % 2);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd2)      addr = addr & 32'hFFFF_FFFC;
        else if (sz == 2'd1) addr = addr & 32'hFFFF_FFFE;
      end
      run_access($sformatf("rand%0d", t), rd, wr, sz, uns, addr, $urandom,
                 $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 2), $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset    = 1'b1;
    exp_data = '0;
    test_reset();
    test_load_word();
    test_load_formats();
    test_store();
    test_misaligned();
    test_timeout();
    test_hold_done();
    test_reset_midflight();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
